// File: rtl/regfile_dec.sv
// Register file with an internal N-to-2^N write-address decoder, two
// asynchronous read ports, optional hardwired r0 and write-to-read bypass.
module regfile_dec #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [ADDR_W-1:0]        raddr_a,
   output logic [DATA_W-1:0]        rdata_a,
   input  logic [ADDR_W-1:0]        raddr_b,
   output logic [DATA_W-1:0]        rdata_b,
   output logic [(1<<ADDR_W)-1:0]   wsel,
   output logic [(1<<ADDR_W)-1:0]   last_wsel,
   output logic [15:0]              wr_count
);

   localparam int unsigned NREG   = 1 << ADDR_W;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic [DATA_W-1:0] regs [NREG];
   logic              zero_hit;
   logic              commit;

   // Decode is deliberately not masked by ZERO_REG; only the commit is.
   for (genvar i = 0; i < NREG; i++) begin : g_dec
      assign wsel[i] = we && (waddr == ADDR_W'(i));
   end

   assign zero_hit = ZERO_REG && (waddr == '0);
   assign commit   = !rst && we && !zero_hit;

   // Array, last-write record and saturating counter share the commit rule.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         last_wsel <= '0;
         wr_count  <= '0;
      end else if (commit) begin
         regs[waddr] <= wdata;
         last_wsel   <= wsel;
         if (wr_count != CNT_MAX) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end

   // Read port A: hardwired zero wins over bypass.
   always_comb begin
      rdata_a = regs[raddr_a];
      if (BYPASS && commit && (raddr_a == waddr)) begin
         rdata_a = wdata;
      end
      if (ZERO_REG && (raddr_a == '0)) begin
         rdata_a = '0;
      end
   end

   // Read port B: same priority as port A.
   always_comb begin
      rdata_b = regs[raddr_b];
      if (BYPASS && commit && (raddr_b == waddr)) begin
         rdata_b = wdata;
      end
      if (ZERO_REG && (raddr_b == '0)) begin
         rdata_b = '0;
      end
   end

endmodule
